// File: rtl/vga_rx_check_if.sv
// Shared VGA geometry and the pixel-stream bundle produced by the draw stages.
package vga_pkg;
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
  localparam int HOR_TOTAL  = 1056;
  localparam int VER_TOTAL  = 628;
endpackage

interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport master (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport slave  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport in     (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/vga_rx_check.sv
// Pixel-stream checker: locks onto the VGA timing, flags timing/content errors
// and produces a per-frame checksum of the active-area rgb values.
module vga_rx_check #(
  parameter int H_ACTIVE = vga_pkg::HOR_PIXELS,
  parameter int V_ACTIVE = vga_pkg::VER_PIXELS,
  parameter int H_TOTAL  = vga_pkg::HOR_TOTAL,
  parameter int V_TOTAL  = vga_pkg::VER_TOTAL
) (
  input  logic        clk40MHz,
  input  logic        rst,
  vga_if.in           in_if,
  input  logic        clr,
  output logic        locked,
  output logic        frame_done,
  output logic [23:0] frame_sum,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt,
  output logic [3:0]  err_flags
);

  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;

  state_t      state_reg, state_next;
  logic [10:0] s1_hcount_reg, s1_vcount_reg;
  logic        s1_hblnk_reg, s1_vblnk_reg;
  logic [11:0] s1_rgb_reg;
  logic [1:0]  s1_sync_unused_reg;
  logic        s1_valid_reg;
  logic [10:0] exp_h_reg, exp_v_reg;
  logic [23:0] acc_reg, frame_sum_reg;
  logic [15:0] frame_cnt_reg;
  logic        frame_done_reg;
  logic [7:0]  err_cnt_reg;
  logic [3:0]  err_flags_reg, err_flags_next;
  logic [3:0]  chk_bits, fail_bits;
  logic        fail, at_origin, at_end, blanking;

  // s1_valid_reg keeps the zeroed post-reset S1 contents from looking like a real (0,0).
  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      s1_hcount_reg      <= '0;
      s1_vcount_reg      <= '0;
      s1_hblnk_reg       <= 1'b0;
      s1_vblnk_reg       <= 1'b0;
      s1_rgb_reg         <= '0;
      s1_sync_unused_reg <= '0;
      s1_valid_reg       <= 1'b0;
    end else begin
      s1_hcount_reg      <= in_if.hcount;
      s1_vcount_reg      <= in_if.vcount;
      s1_hblnk_reg       <= in_if.hblnk;
      s1_vblnk_reg       <= in_if.vblnk;
      s1_rgb_reg         <= in_if.rgb;
      s1_sync_unused_reg <= {in_if.vsync, in_if.hsync};
      s1_valid_reg       <= 1'b1;
    end
  end

  always_comb begin
    at_origin   = (s1_hcount_reg == '0) && (s1_vcount_reg == '0);
    at_end      = (s1_hcount_reg == H_LAST) && (s1_vcount_reg == V_LAST);
    blanking    = s1_hblnk_reg || s1_vblnk_reg;
    chk_bits    = '0;
    chk_bits[0] = s1_hcount_reg != exp_h_reg;
    chk_bits[1] = s1_vcount_reg != exp_v_reg;
    chk_bits[2] = (s1_hblnk_reg != (s1_hcount_reg >= H_ACT)) ||
                  (s1_vblnk_reg != (s1_vcount_reg >= V_ACT));
    chk_bits[3] = (s1_rgb_reg != '0) && blanking;
    fail_bits   = (state_reg == SEARCH) ? 4'b0000 : chk_bits;
    fail        = |fail_bits;
  end

  always_ff @(posedge clk40MHz) begin
    if (rst) state_reg <= SEARCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SEARCH:  if (s1_valid_reg && at_origin) state_next = LOCKING;
      LOCKING: if (fail) state_next = SEARCH;
               else if (at_end) state_next = LOCKED;
      LOCKED:  if (fail) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    locked = (state_reg == LOCKED);
  end

  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      exp_h_reg <= '0;
      exp_v_reg <= '0;
    end else if (state_reg == SEARCH) begin
      exp_h_reg <= (s1_valid_reg && at_origin) ? 11'd1 : 11'd0;
      exp_v_reg <= '0;
    end else if (exp_h_reg == H_LAST) begin
      exp_h_reg <= '0;
      exp_v_reg <= (exp_v_reg == V_LAST) ? 11'd0 : exp_v_reg + 11'd1;
    end else begin
      exp_h_reg <= exp_h_reg + 11'd1;
    end
  end

  // A failing cycle never closes a frame; the partial sum is thrown away.
  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      acc_reg        <= '0;
      frame_sum_reg  <= '0;
      frame_cnt_reg  <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (state_reg == LOCKED && !fail) begin
        acc_reg <= (at_origin ? 24'd0 : acc_reg) + (blanking ? 24'd0 : {12'd0, s1_rgb_reg});
        if (at_end) begin
          frame_sum_reg  <= acc_reg;
          frame_cnt_reg  <= frame_cnt_reg + 16'd1;
          frame_done_reg <= 1'b1;
        end
      end else begin
        acc_reg <= '0;
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_flag
    assign err_flags_next[gi] = clr ? fail_bits[gi] : (err_flags_reg[gi] | fail_bits[gi]);
  end

  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      err_flags_reg <= '0;
      err_cnt_reg   <= '0;
    end else begin
      err_flags_reg <= err_flags_next;
      if (clr)
        err_cnt_reg <= fail ? 8'd1 : 8'd0;
      else if (fail && err_cnt_reg != 8'hFF)
        err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign frame_done = frame_done_reg;
  assign frame_sum  = frame_sum_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign err_cnt    = err_cnt_reg;
  assign err_flags  = err_flags_reg;

endmodule

// File: doc/vga_rx_check.md
VGA_RX_CHECK -- requirements
Module: vga_rx_check

Interface
REQ-001 The block SHALL use clock clk40MHz, reset rst, synchronous, active-high.
REQ-002 Port list (name  direction  width  meaning):
- clk40MHz  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- in_if  vga_if.in  (vcount 11, hcount 11, vsync 1, hsync 1, vblnk 1, hblnk 1, rgb 12)  pixel stream under check, as driven by draw-stage modules
- clr  in  1  one-cycle pulse; clears err_flags and err_cnt
- locked  out  1  stream timing verified and tracking
- frame_done  out  1  one-cycle pulse per completed locked frame
- frame_sum  out  24  active-pixel rgb checksum of last completed frame
- frame_cnt  out  16  completed locked frames
- err_cnt  out  8  timing/content errors, saturating
- err_flags  out  4  sticky error causes
REQ-003 Geometry SHALL come from vga_pkg: HOR_PIXELS=800, VER_PIXELS=600, HOR_TOTAL=1056, VER_TOTAL=628.

Function
REQ-004 All in_if fields SHALL be registered once (stage S1); every check uses S1 values only.
REQ-005 Block SHALL keep expected counters exp_h (0..1055), exp_v (0..627): exp_h increments each cycle, wraps to 0 after 1055 and then exp_v increments, wrapping to 0 after 627.
REQ-006 Per-cycle checks, evaluated in LOCKING and LOCKED: bit0 S1.hcount != exp_h; bit1 S1.vcount != exp_v; bit2 S1.hblnk != (S1.hcount >= 800) or S1.vblnk != (S1.vcount >= 600); bit3 S1.rgb != 0 while S1.hblnk or S1.vblnk.
REQ-007 FSM states SEARCH, LOCKING, LOCKED.
REQ-008 SEARCH: when S1.hcount==0 and S1.vcount==0, SHALL go to LOCKING and load exp_h=1, exp_v=0 for the next cycle; no checks in SEARCH.
REQ-009 LOCKING: any check failing SHALL return to SEARCH; on reaching S1 position (1055,627) with no failure in the frame, SHALL go to LOCKED.
REQ-010 LOCKED: any check failing SHALL go to SEARCH in the next cycle and drop locked.
REQ-011 locked SHALL be 1 exactly while in LOCKED.
REQ-012 A check failure in LOCKING or LOCKED SHALL OR the failing bits into err_flags and increment err_cnt by 1, saturating at 255.
REQ-013 clr SHALL zero err_flags and err_cnt; if a failure occurs the same cycle, the result SHALL be flags = new bits only and err_cnt = 1.
REQ-014 Checksum: while LOCKED and S1 not blanking, acc SHALL add zero-extended S1.rgb modulo 2^24; acc SHALL restart from the pixel at (0,0).
REQ-015 At S1 position (1055,627) in LOCKED with no failure that cycle, next cycle SHALL: frame_sum <= acc, frame_cnt += 1 (wraps at 65535->0), frame_done = 1 for one cycle.
REQ-016 Frame end at the LOCKING->LOCKED transition SHALL NOT produce frame_done, frame_sum or frame_cnt updates.
REQ-017 A failure mid-frame SHALL discard acc; frame_sum keeps its previous value.
REQ-018 Latency: in_if sample at cycle N -> error flag/err_cnt update and state change visible at N+2; frame_done at N+2 after the final sample of the frame.

Reset
REQ-019 On rst: state SEARCH, exp_h/exp_v/acc 0, locked 0, frame_done 0, frame_sum 0, frame_cnt 0, err_cnt 0, err_flags 0, S1 registers 0.
REQ-020 rst mid-frame SHALL take priority over clr and all checks; relock requires a new (0,0).

Verification
REQ-021 Reset, clean 800x600 stream, rgb=12'h001 in active area, 0 in blanking -> locked=1 from frame 2 start; end of frame 2: frame_done pulse, frame_sum=24'h075300, frame_cnt=1, err_cnt=0.
REQ-022 Locked, skip one hcount value (jump 100->102) -> err_flags=4'b0001, err_cnt=1, locked=0 two cycles later; clean stream relocks after one full frame.
REQ-023 Locked, rgb=12'hFFF at hcount=900 -> err_flags[3]=1, err_cnt=1, locked drops.
REQ-024 clr coincident with vcount error -> err_flags=4'b0010, err_cnt=1.
REQ-025 300 forced errors with no clr -> err_cnt=255, not wrapped.
REQ-026 rst asserted at (400,300) while locked -> all outputs 0 next cycle, state SEARCH; no frame_done for the interrupted frame.
